// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types for the 5-stage core: hazard FSM state encoding
// and register-index / trap-latency defaults.
package cpu_ctrl_pkg;

  localparam int REG_W        = 5;
  localparam int TRAP_CYC_DEF = 2;
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WFI  = 2'd1,
    TRAP = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between pipe_hazard_ctrl (master) and the pipeline (slave).
// Optional HAZ_PERF_CNT_EN adds the stall/flush performance counters.
interface pipe_hazard_ctrl_if #(parameter int REG_W = cpu_ctrl_pkg::REG_W);

  logic             mem_stall;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             id_is_wfi;
  logic             id_is_mret;
  logic             intr_pending;

  logic             pc_en;
  logic             pc_load_vec;
  logic             if_id_enable;
  logic             if_id_nop;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             wfi_stall;
  logic             return_intr;
  logic             intr_take;
  logic [1:0]       state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  modport master (
    input  mem_stall, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
           ex_mem_read, ex_branch_taken, id_is_wfi, id_is_mret, intr_pending,
    output pc_en, pc_load_vec, if_id_enable, if_id_nop, if_id_flush,
           id_ex_flush, wfi_stall, return_intr, intr_take, state_o
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport slave (
    output mem_stall, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
           ex_mem_read, ex_branch_taken, id_is_wfi, id_is_mret, intr_pending,
    input  pc_en, pc_load_vec, if_id_enable, if_id_nop, if_id_flush,
           id_ex_flush, wfi_stall, return_intr, intr_take, state_o
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hz_loaduse_det.sv
// Load-use detector: the load in EX writes a register the ID instruction reads.
module hz_loaduse_det
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_W = cpu_ctrl_pkg::REG_W
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             hazard
);

  logic rs1_hit, rs2_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
  assign hazard  = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch, WFI, trap entry, mret.
// Define HAZ_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TRAP_CYC = cpu_ctrl_pkg::TRAP_CYC_DEF,
  parameter int REG_W    = cpu_ctrl_pkg::REG_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  pipe_hazard_ctrl_if.master    hz
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TRAP_CYC - 1);

  hz_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu_hazard;

  logic pc_en, pc_load_vec, if_id_enable, if_id_nop, if_id_flush;
  logic id_ex_flush, wfi_stall, return_intr, intr_take;

  hz_loaduse_det #(.REG_W(REG_W)) u_lu (
    .ex_mem_read (hz.ex_mem_read),
    .ex_rd       (hz.ex_rd),
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_rs1_used (hz.id_rs1_used),
    .id_rs2_used (hz.id_rs2_used),
    .hazard      (lu_hazard)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_en        = 1'b0;
    pc_load_vec  = 1'b0;
    if_id_enable = 1'b0;
    if_id_nop    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    wfi_stall    = 1'b0;
    return_intr  = 1'b0;
    intr_take    = 1'b0;
    unique case (state)
      RUN: begin
        if (hz.mem_stall) begin
          if_id_nop = 1'b1;
        end else if (hz.intr_pending) begin
          // interrupt beats a same-cycle branch; CSR captures mepc from EX
          intr_take   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_nxt     = CNT_INIT;
          state_nxt   = TRAP;
        end else if (hz.ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          pc_en        = 1'b1;
          if_id_enable = 1'b1;
        end else if (hz.id_is_mret) begin
          return_intr  = 1'b1;
          pc_en        = 1'b1;
          if_id_enable = 1'b1;
        end else if (hz.id_is_wfi) begin
          wfi_stall = 1'b1;
          state_nxt = WFI;
        end else if (lu_hazard) begin
          if_id_nop   = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          pc_en        = 1'b1;
          if_id_enable = 1'b1;
        end
      end
      WFI: begin
        wfi_stall = 1'b1;
        if (hz.intr_pending && !hz.mem_stall) begin
          intr_take   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_nxt     = CNT_INIT;
          state_nxt   = TRAP;
        end
      end
      TRAP: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (!hz.mem_stall) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            pc_load_vec  = 1'b1;
            pc_en        = 1'b1;
            if_id_enable = 1'b1;
            state_nxt    = RUN;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign hz.pc_en        = pc_en;
  assign hz.pc_load_vec  = pc_load_vec;
  assign hz.if_id_enable = if_id_enable;
  assign hz.if_id_nop    = if_id_nop;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.wfi_stall    = wfi_stall;
  assign hz.return_intr  = return_intr;
  assign hz.intr_take    = intr_take;
  assign hz.state_o      = state;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)      stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; outputs packed into one word per check.
module tb_pipe_hazard_ctrl;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_err;

  pipe_hazard_ctrl_if #(.REG_W(REG_W)) hz ();

  pipe_hazard_ctrl #(.TRAP_CYC(2), .REG_W(REG_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output word: {pc_en, pc_load_vec, if_id_enable, if_id_nop, if_id_flush,
  //               id_ex_flush, wfi_stall, return_intr, intr_take}
  localparam logic [8:0] PC   = 9'h100;
  localparam logic [8:0] VEC  = 9'h080;
  localparam logic [8:0] EN   = 9'h040;
  localparam logic [8:0] NOP  = 9'h020;
  localparam logic [8:0] IFF  = 9'h010;
  localparam logic [8:0] IDF  = 9'h008;
  localparam logic [8:0] WST  = 9'h004;
  localparam logic [8:0] RET  = 9'h002;
  localparam logic [8:0] TAKE = 9'h001;
  localparam logic [8:0] O_RUN = PC | EN;

  function automatic logic [8:0] outs();
    return {hz.pc_en, hz.pc_load_vec, hz.if_id_enable, hz.if_id_nop, hz.if_id_flush,
            hz.id_ex_flush, hz.wfi_stall, hz.return_intr, hz.intr_take};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    hz.mem_stall = 0; hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 0;
    hz.id_rs2_used = 0; hz.ex_rd = '0; hz.ex_mem_read = 0; hz.ex_branch_taken = 0;
    hz.id_is_wfi = 0; hz.id_is_mret = 0; hz.intr_pending = 0;
  endtask

  // advance one clock, then leave time for inputs to settle mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    resetn = 1'b0;
    clr();
    #12;
    check("reset_state", 32'(hz.state_o), 32'(RUN));
    check("reset_outs", 32'(outs()), 32'(O_RUN));
    @(posedge clk); #1 resetn = 1'b1;

    // load-use on rs1
    hz.ex_mem_read = 1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_rs1_used = 1; #1;
    check("lu_rs1", 32'(outs()), 32'(NOP | IDF));
    tick(); clr(); #1;
    check("lu_after", 32'(outs()), 32'(O_RUN));
    check("lu_state", 32'(hz.state_o), 32'(RUN));

    // load-use on rs2
    hz.ex_mem_read = 1; hz.ex_rd = 5'd17; hz.id_rs2 = 5'd17; hz.id_rs2_used = 1; #1;
    check("lu_rs2", 32'(outs()), 32'(NOP | IDF));
    // x0 destination never stalls
    clr(); hz.ex_mem_read = 1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_rs1_used = 1; #1;
    check("lu_x0", 32'(outs()), 32'(O_RUN));
    // matching but unused source
    clr(); hz.ex_mem_read = 1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; #1;
    check("lu_unused", 32'(outs()), 32'(O_RUN));
    // match without a load
    clr(); hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_rs1_used = 1; #1;
    check("lu_noload", 32'(outs()), 32'(O_RUN));

    // taken branch
    clr(); hz.ex_branch_taken = 1; #1;
    check("branch", 32'(outs()), 32'(PC | EN | IFF | IDF));
    tick(); clr(); #1;
    check("branch_state", 32'(hz.state_o), 32'(RUN));
    check("branch_after", 32'(outs()), 32'(O_RUN));

    // mret
    hz.id_is_mret = 1; #1;
    check("mret", 32'(outs()), 32'(PC | EN | RET));
    // mem_stall overrides everything in RUN
    hz.mem_stall = 1; hz.ex_branch_taken = 1; #1;
    check("memstall_run", 32'(outs()), 32'(NOP));
    tick(); clr(); #1;
    check("memstall_state", 32'(hz.state_o), 32'(RUN));

    // WFI sleep
    hz.id_is_wfi = 1; #1;
    check("wfi_enter", 32'(outs()), 32'(WST));
    tick(); clr(); #1;
    for (int i = 0; i < 10; i++) begin
      check("wfi_hold_state", 32'(hz.state_o), 32'(WFI));
      check("wfi_hold_outs", 32'(outs()), 32'(WST));
      tick();
    end
    hz.intr_pending = 1; hz.mem_stall = 1; #1;
    check("wfi_memstall", 32'(outs()), 32'(WST));
    tick();
    check("wfi_memstall_state", 32'(hz.state_o), 32'(WFI));
    hz.mem_stall = 0; #1;
    check("wfi_wake", 32'(outs()), 32'(WST | TAKE | IFF | IDF));
    tick();
    check("trap1_state", 32'(hz.state_o), 32'(TRAP));
    check("trap1_outs", 32'(outs()), 32'(IFF | IDF));
    tick();
    check("trap2_state", 32'(hz.state_o), 32'(TRAP));
    check("trap2_outs", 32'(outs()), 32'(IFF | IDF | VEC | PC | EN));
    hz.intr_pending = 0;
    tick();
    check("trap_exit_state", 32'(hz.state_o), 32'(RUN));
    check("trap_exit_outs", 32'(outs()), 32'(O_RUN));

    // trap from RUN with mem_stall held 3 cycles in TRAP
    hz.intr_pending = 1; #1;
    check("run_intr", 32'(outs()), 32'(TAKE | IFF | IDF));
    tick(); hz.intr_pending = 0; hz.mem_stall = 1; #1;
    for (int i = 0; i < 3; i++) begin
      check("trap_frozen_state", 32'(hz.state_o), 32'(TRAP));
      check("trap_frozen_outs", 32'(outs()), 32'(IFF | IDF));
      tick();
    end
    hz.mem_stall = 0; #1;
    check("trap_cnt1", 32'(outs()), 32'(IFF | IDF));
    tick();
    check("trap_cnt0", 32'(outs()), 32'(IFF | IDF | VEC | PC | EN));
    tick();
    check("trap2_exit_state", 32'(hz.state_o), 32'(RUN));

    // interrupt + branch + mem_stall: hold, then interrupt wins
    hz.intr_pending = 1; hz.ex_branch_taken = 1; hz.mem_stall = 1; #1;
    check("combo_hold", 32'(outs()), 32'(NOP));
    tick();
    check("combo_hold_state", 32'(hz.state_o), 32'(RUN));
    hz.mem_stall = 0; #1;
    check("combo_take", 32'(outs()), 32'(TAKE | IFF | IDF));
    tick(); clr(); #1;
    check("combo_trap_state", 32'(hz.state_o), 32'(TRAP));
    // asynchronous reset mid-TRAP
    resetn = 1'b0; #1;
    check("rst_mid_trap_state", 32'(hz.state_o), 32'(RUN));
    check("rst_mid_trap_outs", 32'(outs()), 32'(O_RUN));
    tick(); resetn = 1'b1; tick();
    check("post_rst_state", 32'(hz.state_o), 32'(RUN));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V core. It drives the IF/ID pipeline register controls (enable, NOP/hold, flush, WFI stall, interrupt return), the PC enable, and the ID/EX bubble. It resolves load-use hazards, taken branches, memory-wait stalls, WFI sleep, interrupt entry and mret return. A small FSM with a trap-redirect counter sequences these events.

Parameters:
TRAP_CYC, 2, cycles spent in TRAP state (mtvec fetch latency); legal range 1..7
REG_W, 5, register index width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_stall  in  1  IM or DM wrapper busy; freezes the whole pipe
id_rs1  in  REG_W  source reg 1 of the instruction in ID
id_rs2  in  REG_W  source reg 2 of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_W  destination reg of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
id_is_wfi  in  1  ID instruction is WFI
id_is_mret  in  1  ID instruction is MRET
intr_pending  in  1  enabled machine interrupt pending (from CSR)
pc_en  out  1  PC register update enable
pc_load_vec  out  1  PC mux selects mtvec
if_id_enable  out  1  IF/ID refresh enable
if_id_nop  out  1  IF/ID hold
if_id_flush  out  1  IF/ID squash
id_ex_flush  out  1  insert bubble into ID/EX
wfi_stall  out  1  WFI sleep hold to IF/ID
return_intr  out  1  mret redirect; IF/ID drops the fetched instruction
intr_take  out  1  one-cycle pulse; CSR saves mepc and clears MIE
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk. Reset forces state=RUN, cnt=0.
- Outputs are Mealy: combinational from state plus inputs. With all inputs 0 after reset: pc_en=1, if_id_enable=1, all other outputs 0.
- States: RUN=0, WFI=1, TRAP=2. Encoding 3 is unused and recovers to RUN.
- RUN priority, highest first:
  1. mem_stall: pc_en=0, if_id_nop=1, if_id_enable=0, id_ex_flush=0; no state change, all other events ignored.
  2. intr_pending: intr_take=1, if_id_flush=1, id_ex_flush=1, pc_en=0; cnt<=TRAP_CYC-1; next state TRAP.
  3. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_enable=1.
  4. id_is_mret: return_intr=1, pc_en=1, if_id_enable=1; ID/EX not flushed.
  5. id_is_wfi: wfi_stall=1, pc_en=0, if_id_enable=0; next state WFI.
  6. load-use (ex_mem_read, ex_rd!=0, and ex_rd matches a used rs1/rs2): pc_en=0, if_id_nop=1, id_ex_flush=1.
  7. Otherwise: normal advance (pc_en=1, if_id_enable=1).
- WFI:
  - wfi_stall=1, pc_en=0, if_id_enable=0.
  - On intr_pending with mem_stall=0: intr_take=1, if_id_flush=1, id_ex_flush=1; cnt<=TRAP_CYC-1; next state TRAP.
  - mem_stall in WFI keeps WFI.
- TRAP:
  - if_id_flush=1, id_ex_flush=1.
  - cnt>0: pc_en=0; cnt decrements each non-mem_stall cycle.
  - cnt==0 and mem_stall=0: pc_load_vec=1, pc_en=1, if_id_enable=1; next state RUN.
  - mem_stall in TRAP: cnt frozen, pc_en=0, pc_load_vec=0.
- intr_take is asserted for exactly one cycle per trap. intr_pending is ignored while in TRAP.
- Branch and intr_pending in the same cycle: the interrupt wins; the branch target is lost, and mepc=EX PC is the CSR's responsibility.
- Asynchronous reset mid-TRAP or mid-WFI: immediate return to RUN, cnt=0, no pulse emitted.

Optional Feature:
- HAZ_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - stall_cnt increments each cycle pc_en=0.
  - flush_cnt increments each cycle if_id_flush=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_ctrl_pkg: hz_state_e enum (RUN, WFI, TRAP), REG_W constant, TRAP_CYC default.
- Sub-module hz_loaduse_det: combinational load-use compare, instantiated once.
- FSM, counter and output decode stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle of pc_en=0, if_id_nop=1, id_ex_flush=1; next cycle normal.
- Load-use filter: ex_rd=0 with id_rs1=0 -> no stall. Same match with id_rs1_used=0 -> no stall.
- Branch: ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1 for one cycle; state_o stays 0.
- WFI: id_is_wfi=1 -> state WFI, wfi_stall=1 for 10 cycles; intr_pending=1 -> intr_take pulse, TRAP for 2 cycles, pc_load_vec=1 on the 2nd, then RUN.
- mem_stall during TRAP for 3 cycles -> cnt frozen; pc_load_vec delayed by 3 cycles; intr_take appears only once.
- Simultaneous intr_pending + ex_branch_taken + mem_stall=1 -> hold only; on mem_stall drop, the interrupt is taken (intr_take=1); resetn low mid-TRAP -> state_o=0 immediately.
